truth_table_checker: RTL

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 128 ++++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// Collects one response per 3-input vector and grades it against a golden
// truth table; results are held until the next run is started.
module truth_table_checker #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       in_valid,
    input  logic [2:0] in_vec,
    input  logic       in_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] seen,
    output logic [7:0] observed,
    output logic [7:0] mismatch,
    output logic [3:0] err_count,
    output logic       dup_err,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        REPORT
    } state_t;

    state_t      state;
    logic [7:0]  exp_q;
    logic [15:0] cnt;

    logic [7:0]  vec_bit;
    logic        hit;
    logic        accept;
    logic        dup_hit;
    logic [7:0]  seen_next;
    logic        full_next;
    logic [16:0] cnt_inc;
    logic        to_hit;
    logic [7:0]  mis_next;
    logic [3:0]  pop;

    always_comb begin
        vec_bit   = 8'd1 << in_vec;
        hit       = |(seen & vec_bit);
        accept    = in_valid && !hit;
        dup_hit   = in_valid && hit;
        seen_next = accept ? (seen | vec_bit) : seen;
        full_next = (seen_next == 8'hFF);
        cnt_inc   = {1'b0, cnt} + 17'd1;
        to_hit    = (cnt_inc >= 17'(TIMEOUT_CYCLES));
        // Unseen vectors (timeout) are never reported as mismatched.
        mis_next  = (observed ^ exp_q) & seen;
        pop       = 4'd0;
        for (int k = 0; k < 8; k++) begin
            pop = pop + {3'd0, mis_next[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exp_q     <= 8'h00;
            cnt       <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            seen      <= 8'h00;
            observed  <= 8'h00;
            mismatch  <= 8'h00;
            err_count <= 4'd0;
            dup_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, REPORT: begin
                    if (start) begin
                        exp_q     <= expected;
                        cnt       <= 16'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        seen      <= 8'h00;
                        observed  <= 8'h00;
                        mismatch  <= 8'h00;
                        err_count <= 4'd0;
                        dup_err   <= 1'b0;
                        timeout   <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        seen             <= seen_next;
                        observed[in_vec] <= in_o;
                    end
                    if (dup_hit) begin
                        dup_err <= 1'b1;
                    end
                    cnt <= cnt_inc[15:0];
                    // A completing accept beats a simultaneous timeout.
                    if (full_next) begin
                        state <= CHECK;
                    end else if (to_hit) begin
                        timeout <= 1'b1;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    mismatch  <= mis_next;
                    err_count <= pop;
                    pass      <= (seen == 8'hFF) && (mis_next == 8'h00)
                                 && !dup_err && !timeout;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= REPORT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
